fifo_byte_packer: RTL
=====================

Name: fifo_byte_packer

Overview:
- Downstream consumer of the 8-bit sync FIFO.
- Drains bytes via the FIFO read port (r_en/empty/data_out) and packs LANES bytes little-endian into one wide word.
- Presents each word on a valid/ready master interface toward the bus/memory writer.
- Partial words are emitted on an idle timeout or an explicit flush, tagged with a byte-keep mask.

Parameters:
DATA_W, 8, byte width; matches FIFO data width
LANES, 4, bytes per output word; output width = DATA_W*LANES; legal 2..8
TIMEOUT, 16, idle cycles with a partial word before auto-flush; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after fifo_r_en was high with fifo_empty low
fifo_r_en  output  1  FIFO read enable
flush  input  1  single-cycle pulse; request emission of the current partial word
m_data  output  DATA_W*LANES  packed word; byte 0 (first read) at [DATA_W-1:0]
m_keep  output  LANES  per-lane valid mask
m_valid  output  1  word valid
m_ready  input  1  downstream accept

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=FILL, cnt=0, pend=0, idle=0, flush_req=0.
  - m_valid=0, m_data=0, m_keep=0.
  - fifo_r_en is forced 0 while rst==0.
  - Reset mid-word or mid-OUT discards the word. A FIFO read issued in the cycle before reset is lost; this is accepted.
- States: FILL (collecting bytes), OUT (word held on the master port).
- fifo_r_en is combinational: fifo_r_en = rst && state==FILL && !fifo_empty && (cnt+pend < LANES) && !flush_req.
- pend register:
  - Set to fifo_r_en at each edge.
  - When pend==1, fifo_data is written into lane cnt and cnt increments at that edge.
- Transition FILL->OUT at the edge where any of these holds:
  - (a) the capture makes cnt==LANES; m_keep = all ones.
  - (b) flush_req==1, pend==0, cnt>0.
  - (c) TIMEOUT>0, idle==TIMEOUT-1, pend==0, cnt>0.
  - In cases (b) and (c), m_keep has the low cnt bits set and unused lanes of m_data read 0.
- Outputs are registered: m_valid goes high the cycle after the transition edge.
- Latency: with the FIFO holding >=LANES bytes, fifo_r_en is high cycles 0..LANES-1 and m_valid rises in cycle LANES+1 (cycle 5 for LANES=4).
- OUT behaviour:
  - m_data, m_keep and m_valid are held stable until m_valid && m_ready.
  - fifo_r_en stays 0 throughout OUT.
  - On the accept edge: m_valid=0, m_data=0, m_keep=0, cnt=0, flush_req=0, idle=0, state=FILL.
  - One bubble cycle follows each accept, since reads resume only in FILL.
- idle counter:
  - Increments each FILL cycle with cnt>0, pend==0 and fifo_empty==1.
  - Clears on any capture or on leaving FILL.
  - Saturates at TIMEOUT-1.
- flush handling:
  - In FILL with cnt>0 or pend==1, flush sets the sticky flush_req and blocks new reads.
  - Any in-flight byte is captured, then the partial word is emitted.
  - flush with cnt==0 and pend==0 is ignored (no empty words, m_keep never 0).
  - flush during OUT is ignored.
  - flush at the same edge that fills the last lane is absorbed: a full word is emitted and flush_req is cleared on accept.
- Simultaneous timeout and flush produce one emission only.
- Never reads when fifo_empty==1; never over-reads past LANES.

Test Plan:
- Reset hold: rst=0 for 2 cycles with fifo_empty=0 -> fifo_r_en=0, m_valid=0, m_data=0, m_keep=0.
- Full word: FIFO preloaded with 0x11,0x22,0x33,0x44; m_ready=1 -> fifo_r_en high cycles 0-3, m_valid in cycle 5 with m_data=0x44332211 and m_keep=4'b1111, then fifo_r_en back high in the cycle after accept.
- Backpressure: 8 bytes 0x01..0x08, m_ready=0 for 10 cycles -> first word 0x04030201 held stable with fifo_r_en=0; after m_ready=1, second word 0x08070605 arrives.
- Timeout: single byte 0xFA (matching the FIFO bench stimulus), TIMEOUT=16 -> m_valid rises about 17-18 cycles after the capture, m_data=0x000000FA, m_keep=4'b0001.
- Flush: 0xAA,0xBB then a flush pulse while the second read is pending -> m_data=0x0000BBAA, m_keep=4'b0011; flush with cnt==0 -> no m_valid.
- Reset mid-operation: rst=0 while in OUT holding 0x44332211 -> m_valid=0 next cycle; the word is not re-emitted after reset.

Source files
------------

// File: rtl/fifo_byte_packer.sv
// Drains bytes from a sync FIFO read port and packs LANES of them little-endian
// into one word on a valid/ready master port; partial words leave on timeout or flush.
module fifo_byte_packer #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [DATA_W-1:0]        fifo_data,
  output logic                     fifo_r_en,
  input  logic                     flush,
  output logic [DATA_W*LANES-1:0]  m_data,
  output logic [LANES-1:0]         m_keep,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam int CW       = $clog2(LANES + 1);
  localparam int IDLE_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int IW       = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;

  typedef enum logic {S_FILL, S_OUT} state_t;

  state_t                    r_state, w_state_next;
  logic [CW-1:0]             r_cnt;
  logic                      r_pend;
  logic                      r_flush_req;
  logic [IW-1:0]             r_idle;
  logic [DATA_W*LANES-1:0]   r_acc;
  logic [DATA_W*LANES-1:0]   r_data;
  logic [LANES-1:0]          r_keep;
  logic                      r_valid;

  logic [DATA_W*LANES-1:0]   w_acc_next;
  logic [CW-1:0]             w_cnt_next;
  logic [CW:0]               w_fill;
  logic [LANES-1:0]          w_keep;
  logic                      w_rd_en;
  logic                      w_emit_full, w_emit_flush, w_emit_timeout;
  logic                      w_go_out, w_accept;

  assign w_fill     = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
  assign w_rd_en    = rst && (r_state == S_FILL) && !fifo_empty &&
                      (w_fill < (CW+1)'(LANES)) && !r_flush_req;
  assign w_cnt_next = r_cnt + CW'(r_pend);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_acc_next[gi*DATA_W +: DATA_W] =
        (r_pend && (r_cnt == CW'(gi))) ? fifo_data : r_acc[gi*DATA_W +: DATA_W];
      assign w_keep[gi] = (CW'(gi) < w_cnt_next);
    end
  endgenerate

  assign w_emit_full  = r_pend && (w_cnt_next == CW'(LANES));
  assign w_emit_flush = r_flush_req && !r_pend && (r_cnt != '0);
  // A read issued in the timeout cycle would land in OUT and be lost, so it defers the timeout.
  assign w_emit_timeout = (TIMEOUT > 0) && (r_idle == IW'(IDLE_MAX)) && !r_pend &&
                          (r_cnt != '0) && !w_rd_en;
  assign w_accept = (r_state == S_OUT) && r_valid && m_ready;

  always_comb begin
    w_state_next = r_state;
    w_go_out     = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_emit_full || w_emit_flush || w_emit_timeout) begin
          w_state_next = S_OUT;
          w_go_out     = 1'b1;
        end
      end
      S_OUT: begin
        if (w_accept) begin
          w_state_next = S_FILL;
        end
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_idle      <= '0;
      r_flush_req <= 1'b0;
      r_acc       <= '0;
      r_data      <= '0;
      r_keep      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_rd_en;

      if (r_state == S_FILL) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        if (flush && ((r_cnt != '0) || r_pend)) begin
          r_flush_req <= 1'b1;
        end
      end

      if (w_go_out) begin
        r_data  <= w_acc_next;
        r_keep  <= w_keep;
        r_valid <= 1'b1;
      end

      if (w_accept) begin
        r_valid     <= 1'b0;
        r_data      <= '0;
        r_keep      <= '0;
        r_cnt       <= '0;
        r_acc       <= '0;
        r_flush_req <= 1'b0;
      end

      if (w_go_out || r_pend || (r_state != S_FILL)) begin
        r_idle <= '0;
      end else if ((r_cnt != '0) && fifo_empty && (r_idle < IW'(IDLE_MAX))) begin
        r_idle <= r_idle + 1'b1;
      end
    end
  end

  assign fifo_r_en = w_rd_en;
  assign m_data    = r_data;
  assign m_keep    = r_keep;
  assign m_valid   = r_valid;

endmodule
